// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_arbiter
// Description : Register-file write-port master. Merges ALU and load results.
//               ALU results win; loads wait in a FIFO. Optional WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [4:0]                    ld_rd,
    input  logic [DATA_W-1:0]             ld_data,
`ifdef WB_BYPASS_EN
    input  logic [4:0]                    byp_rs1,
    input  logic [4:0]                    byp_rs2,
    output logic                          byp_hit1,
    output logic                          byp_hit2,
    output logic [DATA_W-1:0]             byp_data1,
    output logic [DATA_W-1:0]             byp_data2,
`endif
    output logic                          RegWrite,
    output logic [4:0]                    rd,
    output logic [DATA_W-1:0]             Write_Data,
    output logic [$clog2(FIFO_DEPTH):0]   pending_count
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]         c_X0    = 5'd0;

    // Load-result buffer
    logic [4:0]             r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0]      r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_fifo_vld;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    // Registered write slot
    logic                   r_reg_write;
    logic [4:0]             r_rd;
    logic [DATA_W-1:0]      r_write_data;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_ld_ready;
    logic                   w_enq;
    logic                   w_alu_wr;
    logic                   w_pop;
    logic                   w_head_vld;
    logic [4:0]             w_head_rd;
    logic [DATA_W-1:0]      w_head_data;
    logic [FIFO_DEPTH-1:0]  w_squash;
    logic [FIFO_DEPTH-1:0]  w_vld_next;
    logic [c_CNT_W-1:0]     w_count_next;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_ld_ready = !w_full && !reset;

    // A handshake with rd==x0 completes but stores nothing.
    assign w_enq      = ld_valid && w_ld_ready && (ld_rd != c_X0);
    assign w_alu_wr   = alu_valid && (alu_rd != c_X0);
    assign w_pop      = !w_alu_wr && !w_empty;

    assign w_head_vld  = r_fifo_vld[r_rd_ptr];
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Any buffered load to the ALU's rd is older than the ALU result.
    generate
        for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_squash
            assign w_squash[i] = w_alu_wr && (r_fifo_rd[i] == alu_rd);
        end
    endgenerate

    // The enqueued slot is set after squash, so a same-cycle load to the ALU's rd survives.
    always_comb begin
        w_vld_next = r_fifo_vld & ~w_squash;
        if (w_pop) begin
            w_vld_next[r_rd_ptr] = 1'b0;
        end
        if (w_enq) begin
            w_vld_next[r_wr_ptr] = 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fifo_vld <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_fifo_vld <= w_vld_next;
            r_count    <= w_count_next;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the valid bits and count.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_fifo_rd[r_wr_ptr]   <= ld_rd;
            r_fifo_data[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_rd         <= 5'd0;
            r_write_data <= '0;
        end else if (w_alu_wr) begin
            r_reg_write  <= 1'b1;
            r_rd         <= alu_rd;
            r_write_data <= alu_data;
        end else if (w_pop) begin
            // A squashed head is popped silently.
            r_reg_write <= w_head_vld;
            if (w_head_vld) begin
                r_rd         <= w_head_rd;
                r_write_data <= w_head_data;
            end
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    assign ld_ready      = w_ld_ready;
    assign RegWrite      = r_reg_write;
    assign rd            = r_rd;
    assign Write_Data    = r_write_data;
    assign pending_count = r_count;

`ifdef WB_BYPASS_EN
    // Forward the in-flight write past the register file's pre-edge read.
    assign byp_hit1  = r_reg_write && (r_rd == byp_rs1) && (byp_rs1 != c_X0);
    assign byp_hit2  = r_reg_write && (r_rd == byp_rs2) && (byp_rs2 != c_X0);
    assign byp_data1 = r_write_data;
    assign byp_data2 = r_write_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboarded bench for regfile_writeback_arbiter: directed stimulus pushes
// expected writes; a negedge monitor pops and compares every RegWrite pulse.
module tb_regfile_writeback_arbiter;

    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [4:0]        ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              RegWrite;
    logic [4:0]        rd;
    logic [DATA_W-1:0] Write_Data;
    logic [2:0]        pending_count;

    always #5 clock = ~clock;

    regfile_writeback_arbiter #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .RegWrite      (RegWrite),
        .rd            (rd),
        .Write_Data    (Write_Data),
        .pending_count (pending_count)
    );

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t m_e;
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [DATA_W-1:0] d);
        wr_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
    endtask

    always @(negedge clock) begin
        if (RegWrite === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected: got write rd=%0d data=%0h, expected no write", rd, Write_Data);
            end else begin
                m_e = exp_q.pop_front();
                if (rd === m_e.rd && Write_Data === m_e.data) n_pass++;
                else $display("FAIL wb_write: got rd=%0d data=%0h, expected rd=%0d data=%0h",
                              rd, Write_Data, m_e.rd, m_e.data);
            end
        end
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        check("rst_regwrite", RegWrite, 0);
        check("rst_rd", rd, 0);
        check("rst_wdata", Write_Data, 0);
        check("rst_pending", pending_count, 0);
        check("rst_ld_ready", ld_ready, 0);
        reset = 1'b0;
        tick();
        check("ld_ready_after_rst", ld_ready, 1);

        // ALU write
        expect_wr(5'd5, 64'h1234);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick();
        alu_valid = 1'b0;
        check("alu_regwrite", RegWrite, 1);
        check("alu_rd", rd, 5);
        tick();
        check("alu_one_pulse", RegWrite, 0);

        // Idle load
        expect_wr(5'd7, 64'hAA);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'hAA;
        tick();
        ld_valid = 1'b0;
        check("ld_pending1", pending_count, 1);
        check("ld_not_yet", RegWrite, 0);
        tick();
        check("ld_pending0", pending_count, 0);
        check("ld_latency", RegWrite, 1);

        // Priority: ALU 10,11,12 ahead of buffered load 3, no gaps
        for (int k = 0; k < 3; k++) expect_wr(5'(10 + k), 64'hA0 + 64'(k));
        expect_wr(5'd3, 64'h33);
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h33;
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + k); alu_data = 64'hA0 + 64'(k);
            tick();
            check("prio_gapless", RegWrite, 1);
        end
        alu_valid = 1'b0;
        tick();
        check("prio_load_last", RegWrite, 1);
        check("prio_load_rd", rd, 3);
        tick();

        // Fill and backpressure
        for (int k = 0; k < 5; k++) expect_wr(5'(20 + k), 64'h2000 + 64'(k));
        for (int k = 1; k <= 5; k++) expect_wr(5'(k), 64'h100 + 64'(k));
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 64'h2000 + 64'(k);
            ld_valid = 1'b1; ld_rd = 5'(k + 1); ld_data = 64'h100 + 64'(k + 1);
            tick();
        end
        check("fill_pending4", pending_count, 4);
        check("fill_ready0", ld_ready, 0);
        alu_rd = 5'd24; alu_data = 64'h2004;
        ld_rd = 5'd5; ld_data = 64'h105;
        tick();
        check("fill_held_pending", pending_count, 4);
        check("fill_held_ready", ld_ready, 0);
        alu_valid = 1'b0;
        tick();
        check("fill_pop_pending", pending_count, 3);
        check("fill_pop_ready", ld_ready, 1);
        tick();
        check("fill_enq_pop_pending", pending_count, 3);
        ld_valid = 1'b0;
        repeat (3) tick();
        check("fill_drained", pending_count, 0);

        // Squash: buffered load to r9 overtaken by ALU write to r9
        expect_wr(5'd9, 64'hBB);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h99;
        tick();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'hBB;
        tick();
        alu_valid = 1'b0;
        check("squash_counted", pending_count, 1);
        tick();
        check("squash_silent_pop", RegWrite, 0);
        check("squash_pending0", pending_count, 0);
        check("squash_rd_hold", rd, 9);
        check("squash_data_hold", Write_Data, 64'hBB);

        // Same-cycle ALU and load to r9: load is newer and survives
        expect_wr(5'd9, 64'hDD);
        expect_wr(5'd9, 64'hCC);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'hDD;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'hCC;
        tick();
        idle_inputs();
        tick();
        check("same_rd_load_data", Write_Data, 64'hCC);
        check("same_rd_pending", pending_count, 0);

        // x0 on both paths
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'hBEEF;
        tick();
        check("x0_ld_ready", ld_ready, 1);
        check("x0_pending", pending_count, 0);
        check("x0_no_write", RegWrite, 0);
        tick();
        check("x0_no_write2", RegWrite, 0);
        idle_inputs();
        expect_wr(5'd6, 64'h66);
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 64'h66;
        tick();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hF00D;
        tick();
        alu_valid = 1'b0;
        check("x0_alu_drains", RegWrite, 1);
        check("x0_alu_drains_rd", rd, 6);

        // Reset mid-operation discards buffered loads
        for (int k = 0; k < 3; k++) begin
            expect_wr(5'(21 + k), 64'h3000 + 64'(k));
            alu_valid = 1'b1; alu_rd = 5'(21 + k); alu_data = 64'h3000 + 64'(k);
            ld_valid = 1'b1; ld_rd = 5'(13 + k); ld_data = 64'h130 + 64'(k);
            tick();
        end
        check("rst_mid_pending3", pending_count, 3);
        alu_valid = 1'b0;
        ld_rd = 5'd16;
        reset = 1'b1;
        #1;
        check("rst_mid_ready_comb", ld_ready, 0);
        tick();
        check("rst_mid_pending0", pending_count, 0);
        check("rst_mid_regwrite", RegWrite, 0);
        check("rst_mid_rd", rd, 0);
        check("rst_mid_ready", ld_ready, 0);
        reset = 1'b0;
        ld_valid = 1'b0;
        repeat (8) tick();
        check("rst_mid_stays_empty", pending_count, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
